// File: rtl/ext_mem_slv_if.sv
// Request/ack channel between the register-slave FSM and an external memory-backed slave.
// The master modport is the upstream FSM; the slave modport is the memory window.
interface ext_mem_slv_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                  fsm__slv__req_vld;
  logic                  fsm__slv__rd_en;
  logic                  fsm__slv__wr_en;
  logic [ADDR_WIDTH-1:0] fsm__slv__addr;
  logic [DATA_WIDTH-1:0] fsm__slv__wr_data;
  logic                  fsm__slv__sync_reset;
  logic                  fsm__slv__ack_rdy;
  logic                  slv__fsm__req_rdy;
  logic                  slv__fsm__ack_vld;
  logic [DATA_WIDTH-1:0] slv__fsm__rd_data;
  logic [7:0]            slv__err_cnt;

  modport slave (
    input  fsm__slv__req_vld, fsm__slv__rd_en, fsm__slv__wr_en, fsm__slv__addr,
           fsm__slv__wr_data, fsm__slv__sync_reset, fsm__slv__ack_rdy,
    output slv__fsm__req_rdy, slv__fsm__ack_vld, slv__fsm__rd_data, slv__err_cnt
  );

  modport master (
    output fsm__slv__req_vld, fsm__slv__rd_en, fsm__slv__wr_en, fsm__slv__addr,
           fsm__slv__wr_data, fsm__slv__sync_reset, fsm__slv__ack_rdy,
    input  slv__fsm__req_rdy, slv__fsm__ack_vld, slv__fsm__rd_data, slv__err_cnt
  );
endinterface

// File: rtl/ext_mem_slv.sv
// Memory-backed external register slave: one request at a time, fixed wait, held ack.
// Array access happens at the accept edge; the wait only delays the ack.
module ext_mem_slv #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 2
) (
  input  logic          clk,
  input  logic          rstn,
  ext_mem_slv_if.slave  bus
);

  localparam int OFS   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  req_rdy_reg, req_rdy_next;
  logic [DATA_WIDTH-1:0] resp_reg, resp_next;
  logic [7:0]            err_cnt_reg, err_cnt_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] ofs_addr;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]      widx;
  logic                  in_range;
  logic                  accept;
  logic                  is_wr;
  logic                  is_rd;

  assign ofs_addr = bus.fsm__slv__addr - BASE_ADDR;
  assign idx_full = ofs_addr >> OFS;
  assign widx     = idx_full[IDX_W-1:0];
  assign in_range = (bus.fsm__slv__addr >= BASE_ADDR) && (idx_full < DEPTH_A);
  assign is_wr    = in_range & bus.fsm__slv__wr_en & ~bus.fsm__slv__rd_en;
  assign is_rd    = in_range & bus.fsm__slv__rd_en & ~bus.fsm__slv__wr_en;
  // A soft reset in the same cycle wins over a presented request.
  assign accept   = (state_reg == S_IDLE) & bus.fsm__slv__req_vld & req_rdy_reg &
                    ~bus.fsm__slv__sync_reset;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      req_rdy_reg <= 1'b0;
      resp_reg    <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      req_rdy_reg <= req_rdy_next;
      resp_reg    <= resp_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    resp_next    = resp_reg;
    err_cnt_next = err_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_BUSY;
          cnt_next   = CNT_LOAD;
          resp_next  = is_rd ? mem[widx] : '0;
          if (!(is_wr || is_rd) && (err_cnt_reg != 8'hFF))
            err_cnt_next = err_cnt_reg + 8'd1;
        end
      end
      S_BUSY: begin
        if (cnt_reg == '0) state_next = S_ACK;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      S_ACK: begin
        if (bus.fsm__slv__ack_rdy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (bus.fsm__slv__sync_reset) begin
      state_next   = S_IDLE;
      cnt_next     = '0;
      err_cnt_next = '0;
    end
    // Ready stays low for as long as the soft reset is held.
    req_rdy_next = (state_next == S_IDLE) && !bus.fsm__slv__sync_reset;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          mem[gi] <= '0;
        else if (accept && is_wr && (widx == IDX_W'(gi)))
          mem[gi] <= bus.fsm__slv__wr_data;
      end
    end
  endgenerate

  assign bus.slv__fsm__req_rdy = req_rdy_reg;
  assign bus.slv__fsm__ack_vld = (state_reg == S_ACK);
  assign bus.slv__fsm__rd_data = (state_reg == S_ACK) ? resp_reg : '0;
  assign bus.slv__err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_ext_mem_slv.sv
// Scenario bench for ext_mem_slv: a reference model pushes expected ack data
// into a queue when each request is accepted; acks pop and compare.
module tb_ext_mem_slv;
  localparam int          AW    = 64;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h100;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ext_mem_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ext_mem_slv #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] mdl [DEPTH];
  int          mdl_err = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one request once req_rdy is seen, update the model at the accept edge.
  task automatic send_req(input bit rd, input bit wr, input logic [63:0] a,
                          input logic [31:0] d, input bit track, output bit to);
    logic [63:0] idx;
    bit          inr;
    logic [31:0] expd;
    int          n = 0;
    to = 1'b0;
    @(negedge clk);
    while (bus.slv__fsm__req_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      to = 1'b1;
      return;
    end
    bus.fsm__slv__req_vld = 1'b1;
    bus.fsm__slv__rd_en   = rd;
    bus.fsm__slv__wr_en   = wr;
    bus.fsm__slv__addr    = a;
    bus.fsm__slv__wr_data = d;
    @(posedge clk);
    idx  = (a - BASE) >> 2;
    inr  = (a >= BASE) && (idx < 64'(DEPTH));
    expd = 32'h0;
    if (inr && wr && !rd) mdl[int'(idx[3:0])] = d;
    else if (inr && rd && !wr) expd = mdl[int'(idx[3:0])];
    else if (mdl_err < 255) mdl_err++;
    if (track) exp_q.push_back(expd);
    @(negedge clk);
    bus.fsm__slv__req_vld = 1'b0;
    bus.fsm__slv__rd_en   = 1'b0;
    bus.fsm__slv__wr_en   = 1'b0;
  endtask

  // Wait for ack_vld (bounded), pop the expected value, optionally consume the ack.
  task automatic get_ack(input bit consume, output logic [31:0] data, output logic [31:0] expd,
                         output int lat, output bit leak, output bit to);
    logic old_rdy;
    lat  = 0;
    leak = 1'b0;
    to   = 1'b0;
    while (bus.slv__fsm__ack_vld !== 1'b1 && lat < 50) begin
      if (bus.slv__fsm__rd_data !== 32'h0) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    expd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
    if (lat >= 50) begin
      to   = 1'b1;
      data = 32'hx;
      return;
    end
    data = bus.slv__fsm__rd_data;
    $display("txn ack data=%h exp=%h lat=%0d", data, expd, lat);
    if (consume) begin
      old_rdy = bus.fsm__slv__ack_rdy;
      bus.fsm__slv__ack_rdy = 1'b1;
      @(negedge clk);
      bus.fsm__slv__ack_rdy = old_rdy;
    end
  endtask

  task automatic test_reset();
    bus.fsm__slv__req_vld = 1'b0; bus.fsm__slv__rd_en = 1'b0; bus.fsm__slv__wr_en = 1'b0;
    bus.fsm__slv__addr = '0; bus.fsm__slv__wr_data = '0;
    bus.fsm__slv__sync_reset = 1'b0; bus.fsm__slv__ack_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (bus.slv__fsm__req_rdy !== 1'b0) begin bad++; $display("FAIL reset_req_rdy: got %b want 0", bus.slv__fsm__req_rdy); end
    total++; if (bus.slv__fsm__ack_vld !== 1'b0) begin bad++; $display("FAIL reset_ack_vld: got %b want 0", bus.slv__fsm__ack_vld); end
    total++; if (bus.slv__fsm__rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", bus.slv__fsm__rd_data); end
    total++; if (bus.slv__err_cnt !== 8'h0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.slv__err_cnt); end
    rstn = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.slv__fsm__req_rdy !== 1'b1) begin bad++; $display("FAIL reset_first_rdy: got %b want 1", bus.slv__fsm__req_rdy); end
  endtask

  task automatic test_write_read();
    logic [31:0] d, e;
    int lat;
    bit leak, to;
    send_req(1'b0, 1'b1, BASE + 64'h8, 32'hDEADBEEF, 1'b1, to);
    total++; if (to) begin bad++; $display("FAIL wr_accept: got timeout want accept"); end
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || lat != LAT) begin bad++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
    total++; if (d !== e) begin bad++; $display("FAIL wr_ack_data: got %h want %h", d, e); end
    total++; if (bus.slv__fsm__ack_vld !== 1'b0 || bus.slv__fsm__rd_data !== 32'h0) begin bad++; $display("FAIL wr_ack_drop: got vld=%b data=%h want 0/0", bus.slv__fsm__ack_vld, bus.slv__fsm__rd_data); end
    total++; if (bus.slv__fsm__req_rdy !== 1'b1) begin bad++; $display("FAIL wr_rdy_back: got %b want 1", bus.slv__fsm__req_rdy); end
    send_req(1'b1, 1'b0, BASE + 64'h8, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || lat != LAT) begin bad++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
    total++; if (d !== e || e !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want %h", d, e); end
    total++; if (leak) begin bad++; $display("FAIL rd_data_leak: got nonzero want 0 before ack"); end
  endtask

  task automatic test_ack_stall();
    logic [31:0] d, e;
    int lat;
    bit leak, to;
    send_req(1'b0, 1'b1, BASE + 64'h10, 32'h1234_5678, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    send_req(1'b1, 1'b0, BASE + 64'h10, 32'h0, 1'b1, to);
    get_ack(1'b0, d, e, lat, leak, to);
    total++; if (to || d !== e) begin bad++; $display("FAIL stall_first: got %h want %h", d, e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.slv__fsm__ack_vld !== 1'b1 || bus.slv__fsm__rd_data !== e || bus.slv__fsm__req_rdy !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got vld=%b data=%h rdy=%b want 1/%h/0", i,
                 bus.slv__fsm__ack_vld, bus.slv__fsm__rd_data, bus.slv__fsm__req_rdy, e);
      end
    end
    bus.fsm__slv__ack_rdy = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.slv__fsm__req_rdy !== 1'b1 || bus.slv__fsm__ack_vld !== 1'b0) begin bad++; $display("FAIL stall_release: got rdy=%b vld=%b want 1/0", bus.slv__fsm__req_rdy, bus.slv__fsm__ack_vld); end
    @(negedge clk);
    bus.fsm__slv__ack_rdy = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] d, e;
    int lat;
    bit leak, to;
    send_req(1'b0, 1'b1, BASE, 32'hA5A5_0001, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    send_req(1'b0, 1'b1, BASE + 64'(DEPTH * 4), 32'h1111_1111, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || d !== e || e !== 32'h0) begin bad++; $display("FAIL err_range_ack: got %h want %h", d, e); end
    send_req(1'b1, 1'b1, BASE, 32'hFFFF_FFFF, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || d !== e) begin bad++; $display("FAIL err_both_ack: got %h want %h", d, e); end
    total++; if (bus.slv__err_cnt !== 8'(mdl_err) || mdl_err != 2) begin bad++; $display("FAIL err_cnt2: got %0d want %0d", bus.slv__err_cnt, mdl_err); end
    send_req(1'b1, 1'b0, BASE, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || d !== e || e !== 32'hA5A5_0001) begin bad++; $display("FAIL err_idx0_kept: got %h want %h", d, e); end
    send_req(1'b1, 1'b0, BASE - 64'h4, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    send_req(1'b0, 1'b0, BASE + 64'h3C, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || d !== e) begin bad++; $display("FAIL err_none_ack: got %h want %h", d, e); end
    total++; if (bus.slv__err_cnt !== 8'(mdl_err)) begin bad++; $display("FAIL err_cnt4: got %0d want %0d", bus.slv__err_cnt, mdl_err); end
    send_req(1'b0, 1'b1, BASE + 64'h3F, 32'h3C3C_3C3C, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    send_req(1'b1, 1'b0, BASE + 64'h3C, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || d !== e || e !== 32'h3C3C_3C3C) begin bad++; $display("FAIL last_word: got %h want %h", d, e); end
  endtask

  task automatic test_back_to_back();
    int acc [6];
    int k = 0;
    int nacks = 0;
    logic [31:0] e;
    bus.fsm__slv__ack_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.slv__fsm__ack_vld === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        $display("txn ack data=%h exp=%h", bus.slv__fsm__rd_data, e);
        total++; if (bus.slv__fsm__rd_data !== e) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", nacks, bus.slv__fsm__rd_data, e); end
        nacks++;
      end
      if (bus.slv__fsm__req_rdy === 1'b1 && k < 6) begin
        bus.fsm__slv__req_vld = 1'b1;
        bus.fsm__slv__rd_en   = 1'b1;
        bus.fsm__slv__wr_en   = 1'b0;
        bus.fsm__slv__addr    = BASE + 64'(4 * k);
        exp_q.push_back(mdl[k]);
        acc[k] = c;
        k++;
      end else begin
        bus.fsm__slv__req_vld = 1'b0;
      end
    end
    bus.fsm__slv__req_vld = 1'b0;
    bus.fsm__slv__rd_en   = 1'b0;
    bus.fsm__slv__ack_rdy = 1'b0;
    total++; if (nacks != 6 || k != 6) begin bad++; $display("FAIL b2b_count: got acks=%0d reqs=%0d want 6/6", nacks, k); end
    for (int i = 0; i < 5; i++) begin
      total++; if (k == 6 && acc[i+1] - acc[i] != LAT + 2) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc[i+1] - acc[i], LAT + 2); end
    end
  endtask

  task automatic test_err_saturate();
    logic [31:0] d, e;
    int lat;
    bit leak, to;
    int dbad = 0;
    for (int i = 0; i < 300; i++) begin
      send_req(1'b1, 1'b1, BASE + 64'(4 * (i % DEPTH)), 32'(i), 1'b1, to);
      get_ack(1'b1, d, e, lat, leak, to);
      if (to || d !== e) dbad++;
    end
    total++; if (dbad != 0) begin bad++; $display("FAIL sat_acks: got %0d bad acks want 0", dbad); end
    total++; if (bus.slv__err_cnt !== 8'(mdl_err) || mdl_err != 255) begin bad++; $display("FAIL sat_cnt: got %0d want %0d", bus.slv__err_cnt, mdl_err); end
    @(negedge clk);
    bus.fsm__slv__sync_reset = 1'b1;
    bus.fsm__slv__req_vld = 1'b1; bus.fsm__slv__wr_en = 1'b1;
    bus.fsm__slv__addr = BASE + 64'h8; bus.fsm__slv__wr_data = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    total++; if (bus.slv__fsm__req_rdy !== 1'b0) begin bad++; $display("FAIL sreset_rdy0: got %b want 0", bus.slv__fsm__req_rdy); end
    @(posedge clk); #1;
    total++; if (bus.slv__fsm__req_rdy !== 1'b0 || bus.slv__err_cnt !== 8'h0) begin bad++; $display("FAIL sreset_held: got rdy=%b cnt=%0d want 0/0", bus.slv__fsm__req_rdy, bus.slv__err_cnt); end
    @(negedge clk);
    bus.fsm__slv__sync_reset = 1'b0;
    bus.fsm__slv__req_vld = 1'b0; bus.fsm__slv__wr_en = 1'b0;
    mdl_err = 0;
    send_req(1'b1, 1'b0, BASE + 64'h8, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || d !== e || e !== 32'hDEADBEEF) begin bad++; $display("FAIL sreset_array_kept: got %h want %h", d, e); end
  endtask

  task automatic test_sync_abort();
    logic [31:0] d, e;
    int lat;
    bit leak, to;
    bit seen = 1'b0;
    send_req(1'b0, 1'b1, BASE + 64'hC, 32'hCAFE_F00D, 1'b0, to);
    bus.fsm__slv__sync_reset = 1'b1;
    @(negedge clk);
    bus.fsm__slv__sync_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.slv__fsm__ack_vld !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen) begin bad++; $display("FAIL abort_no_ack: got ack want none"); end
    total++; if (bus.slv__fsm__req_rdy !== 1'b1) begin bad++; $display("FAIL abort_idle: got rdy=%b want 1", bus.slv__fsm__req_rdy); end
    send_req(1'b1, 1'b0, BASE + 64'hC, 32'h0, 1'b1, to);
    get_ack(1'b1, d, e, lat, leak, to);
    total++; if (to || lat != LAT || d !== e || e !== 32'hCAFE_F00D) begin bad++; $display("FAIL abort_write_kept: got %h lat=%0d want %h", d, lat, e); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d, e;
    int lat;
    bit leak, to;
    int zbad = 0;
    send_req(1'b1, 1'b0, BASE + 64'h8, 32'h0, 1'b1, to);
    get_ack(1'b0, d, e, lat, leak, to);
    total++; if (to || bus.slv__fsm__ack_vld !== 1'b1) begin bad++; $display("FAIL arst_in_ack: got vld=%b want 1", bus.slv__fsm__ack_vld); end
    #2 rstn = 1'b0;
    #1;
    total++; if (bus.slv__fsm__ack_vld !== 1'b0 || bus.slv__fsm__req_rdy !== 1'b0 || bus.slv__fsm__rd_data !== 32'h0) begin bad++; $display("FAIL arst_immediate: got vld=%b rdy=%b data=%h want 0/0/0", bus.slv__fsm__ack_vld, bus.slv__fsm__req_rdy, bus.slv__fsm__rd_data); end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    exp_q.delete();
    mdl_err = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send_req(1'b1, 1'b0, BASE + 64'(4 * i), 32'h0, 1'b1, to);
      get_ack(1'b1, d, e, lat, leak, to);
      if (to || d !== e) zbad++;
    end
    total++; if (zbad != 0) begin bad++; $display("FAIL arst_cleared: got %0d nonzero words want 0", zbad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_ack_stall();
    test_errors();
    test_back_to_back();
    test_err_saturate();
    test_sync_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ext_mem_slv.md
# ext_mem_slv

Memory-backed external register slave that terminates the slave side of the register-slave FSM protocol. It accepts one request at a time on the `fsm__slv__*` request channel, performs the read or write against an internal DEPTH-word array after a programmable wait, and returns a held `slv__fsm__ack_vld` with read data until the upstream FSM signals `fsm__slv__ack_rdy`. It is used as an external-slave model in integration, and as the RTL for small scratch/external register windows.

## Interface
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 32, data width; a multiple of 8 and at least 8.
- DEPTH, 16, number of words in the array; at least 1.
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8.
- LATENCY, 2, cycles from request acceptance to `ack_vld` assertion; at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- fsm__slv__req_vld  in  1  request valid.
- fsm__slv__rd_en  in  1  read request; sampled with `req_vld`.
- fsm__slv__wr_en  in  1  write request; sampled with `req_vld`.
- fsm__slv__addr  in  ADDR_WIDTH  byte address.
- fsm__slv__wr_data  in  DATA_WIDTH  write data.
- fsm__slv__sync_reset  in  1  synchronous soft reset / abort.
- fsm__slv__ack_rdy  in  1  upstream ready to take the ack.
- slv__fsm__req_rdy  out  1  slave can accept a request (registered).
- slv__fsm__ack_vld  out  1  response valid (registered, held).
- slv__fsm__rd_data  out  DATA_WIDTH  read data; zero whenever `ack_vld`=0.
- slv__err_cnt  out  8  saturating count of errored requests.

## Operation
- States: S_IDLE, S_BUSY, S_ACK. Reset state is S_IDLE.
- Accept condition: `req_vld & req_rdy` sampled at an edge while in S_IDLE.
- On accept:
  - Go to S_BUSY and load the wait counter with LATENCY-1.
  - Counter width is $clog2(LATENCY+1).
- S_BUSY:
  - Decrement the counter each cycle.
  - When the counter is 0, go to S_ACK.
  - For LATENCY=1, go S_IDLE -> S_BUSY -> S_ACK with a zero counter.
- S_ACK:
  - Hold `ack_vld`=1 and `rd_data` stable.
  - When `ack_rdy` is sampled 1, go to S_IDLE.
- `req_rdy` is registered: it is 1 on the cycle after next_state==S_IDLE, else 0.
- Decode:
  - Byte offset bits: OFS = $clog2(DATA_WIDTH/8).
  - idx = (addr - BASE_ADDR) >> OFS; the low OFS address bits are ignored.
  - in_range = (addr >= BASE_ADDR) && (idx < DEPTH).
- Command classes:
  - Write (`wr_en`=1, `rd_en`=0, in_range): write the array at the accept edge.
  - Read (`rd_en`=1, `wr_en`=0, in_range): capture the array word into the response register at the accept edge.
  - Error (out of range, both enables 0, or both enables 1): no array change; response data is 0; `err_cnt` increments and saturates at 255.
- Every accepted request gets exactly one ack, including errors.
- `fsm__slv__sync_reset`=1 at an edge:
  - next_state = S_IDLE, aborting any pending transaction with no ack.
  - `err_cnt` cleared to 0; array contents kept.
  - A request presented in the same cycle is not accepted and has no array effect.
- `rstn` low:
  - Array cleared to 0.
  - Reset values: `req_rdy`=0, `ack_vld`=0, `rd_data`=0, `err_cnt`=0, counter=0.

## Timing
- Accept at edge T:
  - `req_rdy` falls after T.
  - `ack_vld` rises after edge T+LATENCY.
- Ack consumed at edge A (`ack_rdy`=1 in S_ACK):
  - `ack_vld` falls and `req_rdy` rises after A.
  - The next accept is possible at A+1.
  - Minimum request spacing is LATENCY+2 cycles.
- `ack_rdy` high before S_ACK has no effect.
- `ack_rdy` low in S_ACK stalls indefinitely; no timeout.
- Write data is visible to a read accepted on any later accept edge.
- `req_vld` while `req_rdy`=0 is ignored. The slave does not buffer; upstream holds the request.
- After `rstn` deasserts:
  - `req_rdy` is 1 from the first edge onward.
  - First accept possible at the second edge.
- `sync_reset` asserted at edge S:
  - `ack_vld`=0 after S.
  - `req_rdy`=1 after S unless `sync_reset` is still 1.
  - While `sync_reset` is held, `req_rdy` stays 0.

## Test plan
- Reset, then write 0xDEADBEEF to BASE_ADDR+0x8, then read it back:
  - With LATENCY=2, each `ack_vld` rises 2 cycles after accept.
  - Read `rd_data`=0xDEADBEEF; `rd_data`=0 outside ack cycles.
- Read with `ack_rdy` held low for 5 cycles in S_ACK:
  - `ack_vld` and `rd_data` stay stable for all 5 cycles.
  - `req_rdy`=0 throughout; `req_rdy` rises on the edge `ack_rdy`=1 is sampled.
- Out-of-range write at BASE_ADDR+DEPTH*4, then a request with both enables set, then a read of idx 0:
  - All three are acked.
  - `err_cnt`=2; idx 0 unchanged; the two error acks return data 0.
- Issue 300 error requests:
  - `err_cnt` saturates at 255.
  - `sync_reset` pulse clears it to 0; array contents survive.
- Assert `sync_reset` during S_BUSY of a write:
  - No `ack_vld` is produced.
  - State returns to S_IDLE; the next request completes normally.
  - The aborted write, already applied at accept, reads back as written.
- Assert `rstn` low during S_ACK:
  - `ack_vld` and `req_rdy` go 0 immediately (asynchronous).
  - After release, all words read 0.
